// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with RAW-hazard scoreboard, SP preset and debug tap
//
// Purpose:
//   NREG x DATA_W register file, register 0 hard-wired to zero, register
//   SP_IDX preset to SP_INIT on reset. Two combinational read ports, one
//   synchronous write port, and a per-register pending-write scoreboard
//   (set on issue, cleared on writeback; an issue in the same cycle as a
//   writeback to the same register wins).
//
// Ports:
//   clk                     clock, rising edge
//   reset                   asynchronous, active-high
//   i_rd_addr_a/b           read addresses
//   o_rd_data_a/b           read data (combinational)
//   o_rd_busy_a/b           register has a pending write
//   i_iss_valid/i_iss_addr  mark destination register pending
//   i_wr_en/i_wr_addr/i_wr_data  writeback port
//   i_dbg_addr/o_dbg_data   debug tap, stored contents only
//   o_busy_any              OR of all scoreboard bits
//
// Configuration:
//   RF_BYPASS_EN  when defined, a same-cycle writeback to a read address is
//                 forwarded to rd_data and clears rd_busy for that port.
module reg_file_sb #(
    parameter int          DATA_W  = 32,
    parameter int          NREG    = 32,
    parameter int          ADDR_W  = 5,
    parameter int          SP_IDX  = 29,
    parameter logic [31:0] SP_INIT = 32'h3fc
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] i_rd_addr_a,
    output logic [DATA_W-1:0] o_rd_data_a,
    output logic              o_rd_busy_a,
    input  logic [ADDR_W-1:0] i_rd_addr_b,
    output logic [DATA_W-1:0] o_rd_data_b,
    output logic              o_rd_busy_b,
    input  logic              i_iss_valid,
    input  logic [ADDR_W-1:0] i_iss_addr,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_dbg_addr,
    output logic [DATA_W-1:0] o_dbg_data,
    output logic              o_busy_any
);

    logic [DATA_W-1:0] r_regs [NREG];
    logic [NREG-1:0]   r_busy;
    logic [NREG-1:0]   w_set;
    logic [NREG-1:0]   w_clr;
    logic              w_wr_hit;
    logic              w_iss_hit;
    logic [DATA_W-1:0] w_store_a;
    logic [DATA_W-1:0] w_store_b;

    assign w_wr_hit  = i_wr_en && (i_wr_addr != '0);
    assign w_iss_hit = i_iss_valid && (i_iss_addr != '0);

    always_comb begin
        w_set = '0;
        w_clr = '0;
        w_set[i_iss_addr] = w_iss_hit;
        w_clr[i_wr_addr]  = w_wr_hit;
    end

    // Set is applied after clear so a same-cycle issue keeps the bit high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_busy <= '0;
        else
            r_busy <= (r_busy & ~w_clr) | w_set;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++)
                r_regs[i] <= (i == SP_IDX) ? DATA_W'(SP_INIT) : '0;
        end else if (w_wr_hit) begin
            r_regs[i_wr_addr] <= i_wr_data;
        end
    end

    assign w_store_a  = (i_rd_addr_a == '0) ? '0 : r_regs[i_rd_addr_a];
    assign w_store_b  = (i_rd_addr_b == '0) ? '0 : r_regs[i_rd_addr_b];
    assign o_dbg_data = (i_dbg_addr  == '0) ? '0 : r_regs[i_dbg_addr];
    assign o_busy_any = |r_busy;

`ifdef RF_BYPASS_EN
    logic w_byp_a;
    logic w_byp_b;

    // w_wr_hit already excludes register 0, so r0 is never forwarded.
    assign w_byp_a     = w_wr_hit && (i_wr_addr == i_rd_addr_a);
    assign w_byp_b     = w_wr_hit && (i_wr_addr == i_rd_addr_b);
    assign o_rd_data_a = w_byp_a ? i_wr_data : w_store_a;
    assign o_rd_data_b = w_byp_b ? i_wr_data : w_store_b;
    assign o_rd_busy_a = r_busy[i_rd_addr_a] && !w_byp_a;
    assign o_rd_busy_b = r_busy[i_rd_addr_b] && !w_byp_b;
`else
    assign o_rd_data_a = w_store_a;
    assign o_rd_data_b = w_store_b;
    assign o_rd_busy_a = r_busy[i_rd_addr_a];
    assign o_rd_busy_b = r_busy[i_rd_addr_b];
`endif

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed and randomized checks of reg_file_sb against a behavioural model
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rd_addr_a, rd_addr_b, iss_addr, wr_addr, dbg_addr;
    logic [31:0] rd_data_a, rd_data_b, wr_data, dbg_data;
    logic        rd_busy_a, rd_busy_b, iss_valid, wr_en, busy_any;

    int n_checks = 0;
    int n_err    = 0;

    logic [31:0] m_regs [32];
    bit          m_busy [32];

    reg_file_sb dut (
        .clk         (clk),
        .reset       (reset),
        .i_rd_addr_a (rd_addr_a),
        .o_rd_data_a (rd_data_a),
        .o_rd_busy_a (rd_busy_a),
        .i_rd_addr_b (rd_addr_b),
        .o_rd_data_b (rd_data_b),
        .o_rd_busy_b (rd_busy_b),
        .i_iss_valid (iss_valid),
        .i_iss_addr  (iss_addr),
        .i_wr_en     (wr_en),
        .i_wr_addr   (wr_addr),
        .i_wr_data   (wr_data),
        .i_dbg_addr  (dbg_addr),
        .o_dbg_data  (dbg_data),
        .o_busy_any  (busy_any)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = (i == 29) ? 32'h3fc : 32'h0;
            m_busy[i] = 1'b0;
        end
    endtask

    function automatic bit byp(input logic [4:0] a);
`ifdef RF_BYPASS_EN
        return wr_en && wr_addr != 0 && wr_addr == a;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] exp_data(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (byp(a)) return wr_data;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        return (a != 0) && m_busy[a] && !byp(a);
    endfunction

    function automatic logic exp_any();
        logic r = 1'b0;
        for (int i = 0; i < 32; i++) r |= m_busy[i];
        return r;
    endfunction

    // Mid-cycle comparison of every output against the model.
    always @(negedge clk) begin
        chk("rd_data_a", rd_data_a, exp_data(rd_addr_a));
        chk("rd_data_b", rd_data_b, exp_data(rd_addr_b));
        chk("rd_busy_a", 32'(rd_busy_a), 32'(exp_busy(rd_addr_a)));
        chk("rd_busy_b", 32'(rd_busy_b), 32'(exp_busy(rd_addr_b)));
        chk("dbg_data", dbg_data, (dbg_addr == 0) ? 32'h0 : m_regs[dbg_addr]);
        chk("busy_any", 32'(busy_any), 32'(exp_any()));
    end

    // Advance one clock; the model commits the inputs held across the edge.
    task automatic tick();
        @(posedge clk);
        if (!reset) begin
            if (wr_en && wr_addr != 0) begin
                m_regs[wr_addr] = wr_data;
                m_busy[wr_addr] = 1'b0;
            end
            if (iss_valid && iss_addr != 0) m_busy[iss_addr] = 1'b1;
        end
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        model_reset();
        #2;
        reset = 1'b0;
        #1;
    endtask

    task automatic idle();
        iss_valid = 0; wr_en = 0; iss_addr = 0; wr_addr = 0; wr_data = 0;
    endtask

    initial begin
        reset = 1'b1;
        model_reset();
        rd_addr_a = 0; rd_addr_b = 0; dbg_addr = 0;
        idle();
        tick();
        tick();
        // 1: reset contents, checked while reset is still asserted
        rd_addr_a = 29; rd_addr_b = 1; dbg_addr = 29;
        #1;
        chk("rst_sp_a", rd_data_a, 32'h3fc);
        chk("rst_r1_b", rd_data_b, 32'h0);
        chk("rst_busy_any", 32'(busy_any), 32'h0);
        chk("rst_dbg_sp", dbg_data, 32'h3fc);
        reset = 1'b0;
        tick();
        // 2: write r5, r0 stays zero
        wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF;
        tick();
        idle();
        rd_addr_a = 5; rd_addr_b = 0;
        #1;
        chk("r5_a", rd_data_a, 32'hDEADBEEF);
        chk("r0_b", rd_data_b, 32'h0);
        wr_en = 1; wr_addr = 0; wr_data = 32'h1;
        tick();
        idle();
        rd_addr_a = 0; dbg_addr = 0;
        #1;
        chk("r0_a", rd_data_a, 32'h0);
        chk("r0_dbg", dbg_data, 32'h0);
        // 3: issue r7, pending for 3 cycles, then writeback
        iss_valid = 1; iss_addr = 7;
        tick();
        idle();
        rd_addr_a = 7;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("r7_busy_hold", 32'(rd_busy_a), 32'h1);
            chk("r7_busy_any", 32'(busy_any), 32'h1);
            tick();
        end
        wr_en = 1; wr_addr = 7; wr_data = 32'h55;
        tick();
        idle();
        #1;
        chk("r7_busy_after", 32'(rd_busy_a), 32'h0);
        chk("r7_data", rd_data_a, 32'h55);
        chk("r7_any_after", 32'(busy_any), 32'h0);
        // 4: issue and write r9 in the same cycle
        iss_valid = 1; iss_addr = 9; wr_en = 1; wr_addr = 9; wr_data = 32'hA;
        tick();
        idle();
        rd_addr_a = 9;
        #1;
        chk("r9_data", rd_data_a, 32'hA);
        chk("r9_busy", 32'(rd_busy_a), 32'h1);
        // 5: writeback to busy r3 observed in the same cycle
        iss_valid = 1; iss_addr = 3;
        tick();
        idle();
        rd_addr_a = 3; wr_en = 1; wr_addr = 3; wr_data = 32'h77;
        #1;
`ifdef RF_BYPASS_EN
        chk("r3_same_data", rd_data_a, 32'h77);
        chk("r3_same_busy", 32'(rd_busy_a), 32'h0);
`else
        chk("r3_same_data", rd_data_a, 32'h0);
        chk("r3_same_busy", 32'(rd_busy_a), 32'h1);
`endif
        tick();
        idle();
        #1;
        chk("r3_next_data", rd_data_a, 32'h77);
        chk("r3_next_busy", 32'(rd_busy_a), 32'h0);
        // 6: reset discards pending issues
        iss_valid = 1; iss_addr = 4;
        tick();
        iss_addr = 6;
        tick();
        idle();
        pulse_reset();
        chk("rst_busy_cleared", 32'(busy_any), 32'h0);
        wr_en = 1; wr_addr = 4; wr_data = 32'h1;
        tick();
        idle();
        rd_addr_a = 4;
        #1;
        chk("r4_after_rst", rd_data_a, 32'h1);
        // Randomized traffic; small address window half the time to force collisions.
        for (int n = 0; n < 3000; n++) begin
            logic [4:0] msk;
            msk       = ($urandom_range(1) == 1) ? 5'h07 : 5'h1f;
            rd_addr_a = 5'($urandom) & msk;
            rd_addr_b = 5'($urandom) & msk;
            dbg_addr  = 5'($urandom) & msk;
            iss_valid = ($urandom_range(2) == 0);
            iss_addr  = 5'($urandom) & msk;
            wr_en     = ($urandom_range(1) == 0);
            wr_addr   = 5'($urandom) & msk;
            wr_data   = $urandom;
            if ($urandom_range(199) == 0) pulse_reset();
            tick();
        end
        idle();
        tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
